ifetch_unit: RTL and testbench
==============================

Name: ifetch_unit

Overview:
Instruction-fetch stage directly upstream of the 4 KB synchronous instruction memory. Owns the program counter and drives the word address into the memory. Captures each 32-bit instruction the memory returns one cycle later and hands it, with its PC, to the decode stage over a valid/ready handshake. Supports decode back-pressure and branch/jump redirect with flush of stale fetches.

Parameters:
ADDR_WIDTH, 10, word-address width of instruction memory (1024 words)
RESET_PC, 32'h0000_0000, byte PC loaded on reset; bits [1:0] must be 0

Ports:
clk  input  1  clock
reset  input  1  reset; synchronous, active-high
imem_addr  output  ADDR_WIDTH  word address to instruction memory = pc[ADDR_WIDTH+1:2], combinational from pc
imem_instr  input  32  instruction from memory; valid the cycle after the address was presented
redirect_valid  input  1  branch/jump taken; load new PC and flush
redirect_pc  input  32  byte target; bits [1:0] forced to 0
out_valid  output  1  instruction available to decode
out_ready  input  1  decode accepts this cycle
out_instr  output  32  instruction at FIFO head
out_pc  output  32  byte PC of out_instr

Behaviour:
- State: pc[31:0], inflight (1 bit), inflight_pc[31:0], 2-entry FIFO of {pc,instr} with count 0..2.
- Reset, sampled at posedge: pc=RESET_PC, inflight=0, FIFO count=0. Outputs: out_valid=0, out_instr=0, out_pc=0. imem_addr=RESET_PC[ADDR_WIDTH+1:2]. Memory output during reset is ignored.
- pop = out_valid && out_ready.
- issue = !reset && !redirect_valid && (count + inflight - pop) < 2.
- On issue at posedge: inflight_pc<=pc, inflight<=1, pc<=pc+4 (wraps modulo 2^32). Without issue: inflight<=0.
- Response capture: when inflight==1 and no redirect this cycle, {inflight_pc, imem_instr} is written to the FIFO tail at the posedge. Push and pop may occur in the same cycle; count is updated accordingly.
- out_valid = (count != 0). out_instr/out_pc = FIFO head when valid, else 0. No combinational bypass from imem_instr to outputs.
- Latency: first out_valid 2 cycles after reset deasserts. Steady-state throughput is 1 instruction/cycle with out_ready held high.
- Back-pressure: with out_ready=0, at most 2 instructions are held (count + inflight ≤ 2). Issue stops and pc holds. Head is stable while out_valid && !out_ready.
- Redirect (priority over issue and capture), at posedge:
  - pc<={redirect_pc[31:2],2'b00}; FIFO count<=0; inflight<=0.
  - The memory response arriving the next cycle is discarded.
  - A pop coinciding with the redirect completes (decode consumed it).
  - First new fetch issues the cycle after redirect; its instruction appears 2 cycles after that.
- Back-to-back redirects: the last one wins. Nothing is pushed until a full cycle passes without redirect.
- Address wrap: imem_addr truncates pc, so fetch wraps every 4 KB. out_pc reports the full 32-bit pc.
- Reset mid-operation: all state cleared next edge. Pending FIFO entries and the inflight fetch are lost.

Optional Feature:
FETCH_PERF_EN
- Defined: adds outputs perf_fetch_cnt[31:0] and perf_stall_cnt[31:0], both reset to 0.
  - perf_fetch_cnt increments on each pop.
  - perf_stall_cnt increments each cycle out_valid && !out_ready.
  - Both wrap at 2^32.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Straight-line fetch. Setup: mem[i]=32'h1000_0000+i, out_ready=1, release reset at cycle 0. Required: out_valid first high at cycle 2 with pc=0/instr=1000_0000, then pc=4,8,12 with instr 1000_0001.. on consecutive cycles, no gaps.
- Stall. Setup: hold out_ready=0 for 5 cycles starting when pc=8 is at head. Required: head stays pc=8/1000_0002, count=2, imem_addr constant. On release, pc 8,12,16 delivered on consecutive cycles with none dropped or duplicated.
- Redirect. Setup: redirect_valid=1 with redirect_pc=32'h0000_0103 while pc=0x10 is at head. Required: next cycle out_valid=0; stale 0x14/0x18 never appear; next delivered entry is pc=0x100/1000_0040, 2 cycles after the redirect cycle.
- Redirect + pop. Setup: redirect coincides with out_ready=1 at head pc=0x20. Required: pc 0x20 counted as consumed, then flush as above. Also: two consecutive redirects to 0x40 then 0x80 → first delivered pc=0x80.
- Wrap and reset. Setup: redirect to 0xFFC. Required: out_pc 0xFFC then 0x1000 with instr mem[1023], mem[0]. Setup: assert reset with count=2. Required: next cycle out_valid=0, outputs 0, restart from RESET_PC.
- Perf counters (FETCH_PERF_EN). Setup: 10 pops, 3 stall cycles. Required: perf_fetch_cnt=10, perf_stall_cnt=3; both 0 after reset.

Source files
------------

// File: rtl/ifetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the instruction-memory word address and
// queues {pc,instr} pairs for decode. Optional FETCH_PERF_EN adds fetch/stall counters.
module ifetch_unit #(
   parameter int          ADDR_WIDTH = 10,
   parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
   input  logic                  clk,
   input  logic                  reset,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   input  logic [31:0]           imem_instr,
   input  logic                  redirect_valid,
   input  logic [31:0]           redirect_pc,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [31:0]           out_instr,
   output logic [31:0]           out_pc
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0]           perf_fetch_cnt,
   output logic [31:0]           perf_stall_cnt
`endif
);

   logic [31:0] pc_q, pc_d;
   logic        infl_q, infl_d;
   logic [31:0] infl_pc_q, infl_pc_d;
   logic [1:0]  cnt_q, cnt_d;
   logic [31:0] e0_pc_q, e0_pc_d, e0_ins_q, e0_ins_d;
   logic [31:0] e1_pc_q, e1_pc_d, e1_ins_q, e1_ins_d;
   logic        pop, push, issue;
   logic [2:0]  occ;

   assign imem_addr = pc_q[ADDR_WIDTH+1:2];
   assign out_valid = (cnt_q != 2'd0);
   assign out_pc    = out_valid ? e0_pc_q  : 32'd0;
   assign out_instr = out_valid ? e0_ins_q : 32'd0;

   always_comb begin
      pop       = out_valid && out_ready;
      push      = infl_q && !redirect_valid;
      // Occupancy after this cycle's pop; a new fetch is allowed only if its reply will fit.
      occ       = {1'b0, cnt_q} + {2'b00, infl_q} - {2'b00, pop};
      issue     = !reset && !redirect_valid && (occ < 3'd2);
      pc_d      = pc_q;
      infl_pc_d = infl_pc_q;
      infl_d    = issue;
      cnt_d     = cnt_q;
      e0_pc_d   = e0_pc_q;
      e0_ins_d  = e0_ins_q;
      e1_pc_d   = e1_pc_q;
      e1_ins_d  = e1_ins_q;

      if (issue) begin
         pc_d      = pc_q + 32'd4;
         infl_pc_d = pc_q;
      end

      // Entry 0 is always the head; entry 1 shifts down on pop.
      case ({push, pop})
         2'b10: begin
            if (cnt_q == 2'd0) begin
               e0_pc_d  = infl_pc_q;
               e0_ins_d = imem_instr;
            end else begin
               e1_pc_d  = infl_pc_q;
               e1_ins_d = imem_instr;
            end
            cnt_d = cnt_q + 2'd1;
         end
         2'b01: begin
            e0_pc_d  = e1_pc_q;
            e0_ins_d = e1_ins_q;
            cnt_d    = cnt_q - 2'd1;
         end
         2'b11: begin
            if (cnt_q == 2'd1) begin
               e0_pc_d  = infl_pc_q;
               e0_ins_d = imem_instr;
            end else begin
               e0_pc_d  = e1_pc_q;
               e0_ins_d = e1_ins_q;
               e1_pc_d  = infl_pc_q;
               e1_ins_d = imem_instr;
            end
         end
         default: ;
      endcase

      if (redirect_valid) begin
         pc_d  = redirect_pc & 32'hFFFF_FFFC;
         cnt_d = 2'd0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q   <= RESET_PC;
         infl_q <= 1'b0;
         cnt_q  <= 2'd0;
      end else begin
         pc_q   <= pc_d;
         infl_q <= infl_d;
         cnt_q  <= cnt_d;
      end
   end

   // Payload registers carry no reset; they are only observed through cnt_q.
   always_ff @(posedge clk) begin
      infl_pc_q <= infl_pc_d;
      e0_pc_q   <= e0_pc_d;
      e0_ins_q  <= e0_ins_d;
      e1_pc_q   <= e1_pc_d;
      e1_ins_q  <= e1_ins_d;
   end

`ifdef FETCH_PERF_EN
   logic [31:0] fetch_cnt_q, stall_cnt_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_cnt_q <= 32'd0;
         stall_cnt_q <= 32'd0;
      end else begin
         if (pop)
            fetch_cnt_q <= fetch_cnt_q + 32'd1;
         if (out_valid && !out_ready)
            stall_cnt_q <= stall_cnt_q + 32'd1;
      end
   end

   assign perf_fetch_cnt = fetch_cnt_q;
   assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// Scoreboard bench for ifetch_unit: stimulus flushes/refills an expected PC stream,
// a negedge monitor checks every delivered instruction and the valid timing rule.
module tb_ifetch_unit;
   localparam int AW = 10;

   logic          clk = 1'b0;
   logic          reset;
   logic [AW-1:0] imem_addr;
   logic [31:0]   imem_instr;
   logic          redirect_valid;
   logic [31:0]   redirect_pc;
   logic          out_valid;
   logic          out_ready;
   logic [31:0]   out_instr;
   logic [31:0]   out_pc;
`ifdef FETCH_PERF_EN
   logic [31:0]   perf_fetch_cnt;
   logic [31:0]   perf_stall_cnt;
`endif

   always #5 clk = ~clk;

   ifetch_unit #(.ADDR_WIDTH(AW), .RESET_PC(32'h0000_0000)) dut (
      .clk(clk),
      .reset(reset),
      .imem_addr(imem_addr),
      .imem_instr(imem_instr),
      .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_instr(out_instr),
      .out_pc(out_pc)
`ifdef FETCH_PERF_EN
      ,
      .perf_fetch_cnt(perf_fetch_cnt),
      .perf_stall_cnt(perf_stall_cnt)
`endif
   );

   logic [31:0] mem [0:1023];
   always @(posedge clk) imem_instr <= mem[imem_addr];

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Expected delivery stream: consecutive PCs from the last reset/redirect target.
   logic [31:0] exp_q[$];
   logic [31:0] nxt_pc = 32'd0;

   task automatic refill();
      while (exp_q.size() < 8) begin
         exp_q.push_back(nxt_pc);
         nxt_pc = nxt_pc + 32'd4;
      end
   endtask

   // Monitor: at each negedge, out_valid must equal "no reset/redirect at the last two edges".
   initial begin
      bit h1 = 1'b0, h2 = 1'b0, hold = 1'b0;
      logic [31:0] hold_pc = '0, hold_ins = '0;
      logic [31:0] m_fetch = '0, m_stall = '0;
      forever begin
         @(negedge clk);
         chk("valid_timing", {31'd0, out_valid}, {31'd0, h1 && h2});
         if (!out_valid) begin
            chk("idle_pc", out_pc, 32'd0);
            chk("idle_instr", out_instr, 32'd0);
         end
         if (hold) begin
            chk("hold_pc", out_pc, hold_pc);
            chk("hold_instr", out_instr, hold_ins);
         end
`ifdef FETCH_PERF_EN
         chk("perf_fetch", perf_fetch_cnt, m_fetch);
         chk("perf_stall", perf_stall_cnt, m_stall);
         if (reset) begin
            m_fetch = '0;
            m_stall = '0;
         end else begin
            if (out_valid && out_ready) m_fetch = m_fetch + 32'd1;
            if (out_valid && !out_ready) m_stall = m_stall + 32'd1;
         end
`else
         m_fetch = m_fetch + {31'd0, out_valid && out_ready};
         m_stall = m_stall + {31'd0, out_valid && !out_ready};
`endif
         if (out_valid && out_ready && !reset) begin
            if (exp_q.size() == 0) begin
               chk("sb_empty", 32'd1, 32'd0);
            end else begin
               chk("pop_pc", out_pc, exp_q[0]);
               chk("pop_instr", out_instr, mem[exp_q[0][11:2]]);
               void'(exp_q.pop_front());
               refill();
            end
         end
         hold     = out_valid && !out_ready && !reset && !redirect_valid;
         hold_pc  = out_pc;
         hold_ins = out_instr;
         if (reset) begin
            exp_q.delete();
            nxt_pc = 32'd0;
            refill();
         end else if (redirect_valid) begin
            exp_q.delete();
            nxt_pc = redirect_pc & 32'hFFFF_FFFC;
            refill();
         end
         h2 = h1;
         h1 = !reset && !redirect_valid;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_head(input logic [31:0] pc, input string nm);
      bit found = 1'b0;
      for (int k = 0; k < 40 && !found; k++) begin
         if (out_valid && out_pc == pc) found = 1'b1;
         else tick();
      end
      chk(nm, {31'd0, found}, 32'd1);
   endtask

   initial begin
      logic [AW-1:0] held_addr;
      for (int i = 0; i < 1024; i++) mem[i] = 32'h1000_0000 + i;
      reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b1;
      repeat (3) tick();
      chk("reset_valid", {31'd0, out_valid}, 32'd0);
      chk("reset_addr", {22'd0, imem_addr}, 32'd0);

      // Straight-line fetch: first instruction two edges after reset release.
      reset = 1'b0;
      tick();
      chk("lat1_valid", {31'd0, out_valid}, 32'd0);
      tick();
      chk("lat2_valid", {31'd0, out_valid}, 32'd1);
      chk("first_pc", out_pc, 32'd0);
      chk("first_instr", out_instr, 32'h1000_0000);
      tick();
      chk("second_pc", out_pc, 32'd4);
      tick();
      chk("third_pc", out_pc, 32'd8);

      // Stall with pc=8 at head.
      out_ready = 1'b0;
      held_addr = imem_addr;
      repeat (5) begin
         tick();
         chk("stall_pc", out_pc, 32'd8);
         chk("stall_instr", out_instr, 32'h1000_0002);
         chk("stall_addr", {22'd0, imem_addr}, {22'd0, held_addr});
      end
      out_ready = 1'b1;
      tick();
      chk("release_pc12", out_pc, 32'd12);
      tick();
      chk("release_pc16", out_pc, 32'd16);

      // Redirect while pc=0x10 is at head (and being popped).
      wait_head(32'h10, "wait_0x10");
      redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
      tick();
      redirect_valid = 1'b0;
      chk("redir_v0", {31'd0, out_valid}, 32'd0);
      tick();
      chk("redir_v1", {31'd0, out_valid}, 32'd0);
      tick();
      chk("redir_v2", {31'd0, out_valid}, 32'd1);
      chk("redir_pc", out_pc, 32'h100);
      chk("redir_instr", out_instr, 32'h1000_0040);

      // Back-to-back redirects coinciding with a pop: the last one wins.
      wait_head(32'h108, "wait_0x108");
      redirect_valid = 1'b1; redirect_pc = 32'h40;
      tick();
      redirect_pc = 32'h80;
      tick();
      redirect_valid = 1'b0;
      chk("dbl_v0", {31'd0, out_valid}, 32'd0);
      tick();
      chk("dbl_v1", {31'd0, out_valid}, 32'd0);
      tick();
      chk("dbl_pc", out_pc, 32'h80);
      chk("dbl_instr", out_instr, 32'h1000_0020);

      // Address wrap at 4 KB.
      redirect_valid = 1'b1; redirect_pc = 32'h0000_0FFC;
      tick();
      redirect_valid = 1'b0;
      repeat (2) tick();
      chk("wrap_pc0", out_pc, 32'hFFC);
      chk("wrap_instr0", out_instr, 32'h1000_03FF);
      tick();
      chk("wrap_pc1", out_pc, 32'h1000);
      chk("wrap_instr1", out_instr, 32'h1000_0000);

      // Reset with a full FIFO.
      out_ready = 1'b0;
      repeat (4) tick();
      chk("full_pc", out_pc, 32'h1000);
      reset = 1'b1;
      tick();
      chk("rst_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_pc", out_pc, 32'd0);
      chk("rst_instr", out_instr, 32'd0);
      chk("rst_addr", {22'd0, imem_addr}, 32'd0);
      reset = 1'b0;
      repeat (2) tick();
      chk("restart_pc", out_pc, 32'd0);
      chk("restart_instr", out_instr, 32'h1000_0000);

      // Ten pops then three stall cycles after a fresh reset.
      reset = 1'b1; out_ready = 1'b1;
      tick();
`ifdef FETCH_PERF_EN
      chk("perf_rst_fetch", perf_fetch_cnt, 32'd0);
      chk("perf_rst_stall", perf_stall_cnt, 32'd0);
`endif
      reset = 1'b0;
      repeat (12) tick();
      out_ready = 1'b0;
      repeat (3) tick();
`ifdef FETCH_PERF_EN
      chk("perf_fetch10", perf_fetch_cnt, 32'd10);
      chk("perf_stall3", perf_stall_cnt, 32'd3);
`endif
      chk("perf_head", out_pc, 32'd40);

      // Randomised traffic; the monitor checks every cycle.
      for (int c = 0; c < 3000; c++) begin
         reset          = ($urandom_range(0, 299) == 0);
         redirect_valid = !reset && ($urandom_range(0, 15) == 0);
         redirect_pc    = $urandom;
         out_ready      = ($urandom_range(0, 3) != 0);
         tick();
      end
      reset = 1'b0; redirect_valid = 1'b0; out_ready = 1'b1;
      repeat (5) tick();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
